// File: rtl/hub_pkg.sv
// Shared hub-port types: FSM encoding, transfer-size codes, held request fields and ack timeout default.
// Pure declarations with no latency; backpressure is not applicable.
package hub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_ACK  = 2'd2
    } hub_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_WORD = 2'b01,
        SZ_LONG = 2'b10,
        SZ_SYS  = 2'b11
    } hub_size_e;

    // Number of hub strobes to wait for our ack bit before giving up on a request.
    localparam logic [3:0] ACK_TMO_DEFAULT = 4'd15;

    typedef struct packed {
        logic       r;
        logic       w;
        hub_size_e  s;
        logic [15:0] a;
        logic [31:0] d;
    } hub_op_t;

endpackage

// File: rtl/hub_port_tmo.sv
// Ack-wait counter: clear/increment on hub strobes, term_o flags that the next increment reaches LIMIT.
// Latency: one clock per update with a combinational flag; it applies no backpressure.
module hub_port_tmo
    import hub_pkg::*;
#(
    parameter logic [3:0] LIMIT = ACK_TMO_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic term_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The flag depends only on the count, so the caller can gate inc_i on it without a loop.
    assign term_o = (cnt_q == (LIMIT - 4'd1));

endmodule

// File: rtl/hub_port.sv
// Cog-side hub port: holds one request, drives it on the bus during our slot, then waits for the ack or a timeout.
// Latency: done/tmo one clock after the deciding strobe; req is ignored while busy or while done is high.
module hub_port
    import hub_pkg::*;
#(
    parameter logic [3:0] ACK_TMO = ACK_TMO_DEFAULT
) (
    input  logic        clk_cog,
    input  logic        res,
    input  logic        ena_bus,
    input  logic        sel,
    input  logic [2:0]  id,
    input  logic        req,
    input  logic        op_r,
    input  logic        op_w,
    input  logic [1:0]  op_s,
    input  logic [15:0] op_a,
    input  logic [31:0] op_d,
    output logic        bus_r,
    output logic        bus_e,
    output logic        bus_w,
    output logic [1:0]  bus_s,
    output logic [15:0] bus_a,
    output logic [31:0] bus_d,
    input  logic [7:0]  bus_ack,
    input  logic [31:0] bus_q,
    input  logic        bus_c,
    output logic        busy,
    output logic        done,
    output logic        tmo,
    output logic [31:0] res_q,
    output logic        res_c
);

    hub_state_e  st_q, st_d;
    hub_op_t     hold_q, hold_d;
    logic [31:0] res_q_d;
    logic        res_c_d;
    logic        done_q, done_d;
    logic        tmo_q, tmo_d;
    logic        cnt_clr, cnt_inc, cnt_term;
    logic        ack_hit;
    logic        drive;

    assign ack_hit = bus_ack[id];

    hub_port_tmo #(
        .LIMIT (ACK_TMO)
    ) u_tmo (
        .clk_i  (clk_cog),
        .rst_i  (res),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .term_o (cnt_term)
    );

    always_comb begin
        st_d    = st_q;
        hold_d  = hold_q;
        res_q_d = res_q;
        res_c_d = res_c;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (st_q)
            ST_IDLE: begin
                // The done clock still belongs to the finished request.
                if (req && !done_q) begin
                    hold_d = '{r: op_r, w: op_w, s: hub_size_e'(op_s), a: op_a, d: op_d};
                    st_d   = ST_PEND;
                end
            end
            ST_PEND: begin
                if (sel && ena_bus) begin
                    cnt_clr = 1'b1;
                    st_d    = ST_ACK;
                end
            end
            ST_ACK: begin
                if (ena_bus) begin
                    if (ack_hit) begin
                        res_q_d = bus_q;
                        res_c_d = bus_c;
                        done_d  = 1'b1;
                        st_d    = ST_IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                        if (cnt_term) begin
                            tmo_d = 1'b1;
                            st_d  = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            st_q   <= ST_IDLE;
            hold_q <= '0;
            res_q  <= 32'd0;
            res_c  <= 1'b0;
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            hold_q <= hold_d;
            res_q  <= res_q_d;
            res_c  <= res_c_d;
            done_q <= done_d;
            tmo_q  <= tmo_d;
        end
    end

    // Outputs are zero when not driving so several cogs can be OR-ed onto the hub.
    assign drive = (st_q == ST_PEND) && sel;
    assign bus_e = drive;
    assign bus_r = drive & hold_q.r;
    assign bus_w = drive & hold_q.w;
    assign bus_s = drive ? 2'(hold_q.s) : 2'b00;
    assign bus_a = drive ? hold_q.a : 16'd0;
    assign bus_d = drive ? hold_q.d : 32'd0;

    assign busy = (st_q != ST_IDLE);
    assign done = done_q;
    assign tmo  = tmo_q;

endmodule

// File: tb/tb_hub_port.sv
// Directed bench for hub_port: write/read transfers, busy and done-clock req rejection, foreign acks, timeout, collision, async reset.
module tb_hub_port;

    logic        clk_cog = 1'b0;
    logic        res;
    logic        ena_bus, sel, req, op_r, op_w, bus_c;
    logic [2:0]  id;
    logic [1:0]  op_s;
    logic [15:0] op_a;
    logic [31:0] op_d, bus_q;
    logic [7:0]  bus_ack;
    logic        bus_r, bus_e, bus_w, busy, done, tmo, res_c;
    logic [1:0]  bus_s;
    logic [15:0] bus_a;
    logic [31:0] bus_d, res_q;

    int checks = 0;
    int failures = 0;

    always #5 clk_cog = ~clk_cog;

    hub_port #(.ACK_TMO(4'd15)) dut (
        .clk_cog (clk_cog), .res (res), .ena_bus (ena_bus), .sel (sel), .id (id),
        .req (req), .op_r (op_r), .op_w (op_w), .op_s (op_s), .op_a (op_a), .op_d (op_d),
        .bus_r (bus_r), .bus_e (bus_e), .bus_w (bus_w), .bus_s (bus_s), .bus_a (bus_a), .bus_d (bus_d),
        .bus_ack (bus_ack), .bus_q (bus_q), .bus_c (bus_c),
        .busy (busy), .done (done), .tmo (tmo), .res_q (res_q), .res_c (res_c)
    );

    task automatic cyc();
        @(posedge clk_cog);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        ena_bus = 0; sel = 0; req = 0; op_r = 0; op_w = 0; op_s = 0; op_a = 0; op_d = 0;
        bus_ack = 0; bus_q = 0; bus_c = 0;
    endtask

    initial begin
        clr_in();
        id  = 3'd0;
        res = 1'b1;
        cyc();
        cyc();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tmo", tmo, 0);
        chk("rst_res_q", res_q, 0);
        chk("rst_res_c", res_c, 0);
        chk("rst_bus_e", bus_e, 0);

        // wrlong, with req on the first edge after reset release
        res = 0; req = 1; op_w = 1; op_s = 2'b10; op_a = 16'h1234; op_d = 32'hDEADBEEF;
        cyc();
        clr_in();
        #1;
        chk("wr_busy_accept", busy, 1);
        chk("wr_nodrive_idle_slot", bus_e, 0);
        for (int i = 1; i <= 2; i++) begin
            ena_bus = 1;
            #1;
            chk("wr_no_sel_bus_d", bus_d, 0);
            cyc();
            ena_bus = 0;
        end
        ena_bus = 1; sel = 1;
        #1;
        chk("wr_bus_d", bus_d, 32'hDEADBEEF);
        chk("wr_bus_a", bus_a, 16'h1234);
        chk("wr_bus_w", bus_w, 1);
        chk("wr_bus_r", bus_r, 0);
        chk("wr_bus_s", bus_s, 2'b10);
        chk("wr_bus_e", bus_e, 1);
        cyc();
        ena_bus = 0;
        #1;
        chk("wr_ack_bus_d_zero", bus_d, 0);
        chk("wr_ack_bus_e_zero", bus_e, 0);
        sel = 0;
        ena_bus = 1;
        cyc();
        ena_bus = 0;
        chk("wr_no_early_done", done, 0);
        cyc();
        ena_bus = 1; bus_ack = 8'h01;
        cyc();
        clr_in();
        chk("wr_done", done, 1);
        chk("wr_done_tmo", tmo, 0);
        chk("wr_busy_low", busy, 0);
        // req on the done clock is dropped
        req = 1; op_r = 1; op_a = 16'h5555;
        cyc();
        clr_in();
        chk("wr_done_one_cycle", done, 0);
        chk("done_clock_req_ignored", busy, 0);

        // rdbyte with id=5, req on the clock after done
        id = 3'd5;
        req = 1; op_r = 1; op_s = 2'b00; op_a = 16'h0042;
        cyc();
        clr_in();
        chk("rd_accept", busy, 1);
        ena_bus = 1; bus_ack = 8'h20;
        cyc();
        clr_in();
        chk("rd_ack_in_pend_busy", busy, 1);
        chk("rd_ack_in_pend_done", done, 0);
        req = 1; op_a = 16'hFFFF; op_w = 1;
        cyc();
        clr_in();
        ena_bus = 1; sel = 1;
        #1;
        chk("busy_ignore_bus_a", bus_a, 16'h0042);
        chk("rd_bus_r", bus_r, 1);
        chk("rd_bus_w", bus_w, 0);
        chk("rd_bus_s", bus_s, 2'b00);
        cyc();
        clr_in();
        ena_bus = 1; bus_ack = 8'hDF; bus_q = 32'hFFFFFFFF; bus_c = 1;
        cyc();
        clr_in();
        chk("rd_foreign_done", done, 0);
        chk("rd_foreign_busy", busy, 1);
        ena_bus = 1; bus_ack = 8'h20; bus_q = 32'h000000A5; bus_c = 1;
        cyc();
        clr_in();
        chk("rd_done", done, 1);
        chk("rd_res_q", res_q, 32'h000000A5);
        chk("rd_res_c", res_c, 1);
        cyc();
        chk("rd_done_one_cycle", done, 0);

        // foreign ack until timeout, id=0
        id = 3'd0;
        req = 1; op_r = 1; op_a = 16'h0100;
        cyc();
        clr_in();
        ena_bus = 1; sel = 1;
        cyc();
        clr_in();
        for (int i = 1; i <= 15; i++) begin
            ena_bus = 1; bus_ack = 8'b00000010; bus_q = 32'hFFFFFFFF; bus_c = 0;
            cyc();
            clr_in();
            chk("tmo_pulse", tmo, (i == 15));
            chk("tmo_no_done", done, 0);
            chk("tmo_busy", busy, (i < 15));
        end
        chk("tmo_res_q_kept", res_q, 32'h000000A5);
        chk("tmo_res_c_kept", res_c, 1);
        cyc();
        chk("tmo_one_cycle", tmo, 0);

        // ack on the strobe that would time out
        req = 1; op_w = 1; op_a = 16'h0200;
        cyc();
        clr_in();
        ena_bus = 1; sel = 1;
        cyc();
        clr_in();
        for (int i = 1; i <= 14; i++) begin
            ena_bus = 1;
            cyc();
            clr_in();
        end
        chk("coll_still_busy", busy, 1);
        ena_bus = 1; bus_ack = 8'h01; bus_q = 32'h12345678; bus_c = 0;
        cyc();
        clr_in();
        chk("coll_done", done, 1);
        chk("coll_tmo", tmo, 0);
        chk("coll_res_q", res_q, 32'h12345678);
        chk("coll_res_c", res_c, 0);
        cyc();
        chk("coll_tmo_after", tmo, 0);

        // reset while driving in PEND
        req = 1; op_w = 1; op_a = 16'h0300; op_d = 32'hCAFEF00D;
        cyc();
        clr_in();
        sel = 1;
        #1;
        chk("rstp_driving", bus_d, 32'hCAFEF00D);
        #1;
        res = 1;
        #1;
        chk("rstp_bus_e", bus_e, 0);
        chk("rstp_bus_d", bus_d, 0);
        chk("rstp_busy", busy, 0);
        cyc();
        res = 0; sel = 0;

        // reset mid-ACK
        req = 1; op_r = 1; op_a = 16'h0400;
        cyc();
        clr_in();
        ena_bus = 1; sel = 1;
        cyc();
        clr_in();
        ena_bus = 1;
        cyc();
        clr_in();
        chk("rsta_busy_before", busy, 1);
        #2;
        res = 1;
        #1;
        chk("rsta_busy", busy, 0);
        chk("rsta_bus_e", bus_e, 0);
        chk("rsta_bus_a", bus_a, 0);
        chk("rsta_res_q", res_q, 0);
        cyc();
        res = 0;
        ena_bus = 1; bus_ack = 8'h01; bus_q = 32'h00000077; bus_c = 1;
        cyc();
        clr_in();
        chk("rsta_no_done", done, 0);
        chk("rsta_no_tmo", tmo, 0);
        chk("rsta_res_q_after", res_q, 0);
        chk("rsta_idle", busy, 0);
        cyc();
        chk("rsta_no_done_later", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
